// File: rtl/sp_ram_pkg.sv
// Shared types and address helpers for the banked, power-managed data RAM.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } bank_state_e;

  // Bank index: low bits of the word address (word-interleaved banks).
  function automatic logic [31:0] bank_of(input logic [31:0] byte_addr,
                                          input int unsigned byte_bits,
                                          input int unsigned bank_bits);
    logic [31:0] word_addr;
    word_addr = byte_addr >> byte_bits;
    return word_addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  // Row inside a bank: word address with the bank bits stripped.
  function automatic logic [31:0] row_of(input logic [31:0] byte_addr,
                                         input int unsigned byte_bits,
                                         input int unsigned bank_bits);
    return byte_addr >> (byte_bits + bank_bits);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Generic single-port RAM macro model: synchronous read, byte-masked write.
module sp_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 256
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en_i) rdata_d = mem[addr_i];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en_i && we_i) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_bank_pm.sv
// One bank's power FSM: idle countdown to SLEEP, timed WAKE back to ACTIVE.
module sp_ram_bank_pm
  import sp_ram_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_i,
  input  logic sleep_en_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic active_o,
  output logic sleep_o,
  output logic mem_en_allow_o
);

  localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((IDLE_CYCLES == 0) ? 32'd0 : IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  bank_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             sleep_q, sleep_d;
  logic             mem_en_allow_q, mem_en_allow_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACTIVE: begin
        // A grant in the expiry cycle keeps the bank awake; idle count saturates.
        if (gnt_i) begin
          cnt_d = '0;
        end else if (IDLE_CYCLES == 0) begin
          cnt_d = '0;
        end else if (cnt_q != IDLE_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (sleep_en_i) begin
          state_d = SLEEP;
          cnt_d   = '0;
        end
      end
      SLEEP: begin
        if (req_i) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    endcase
    active_d       = (state_d == ACTIVE);
    sleep_d        = (state_d != ACTIVE);
    mem_en_allow_d = (state_d != SLEEP);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q        <= ACTIVE;
      cnt_q          <= '0;
      active_q       <= 1'b1;
      sleep_q        <= 1'b0;
      mem_en_allow_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      sleep_q        <= sleep_d;
      mem_en_allow_q <= mem_en_allow_d;
    end
  end

  assign active_o       = active_q;
  assign sleep_o        = sleep_q;
  assign mem_en_allow_o = mem_en_allow_q;

endmodule

// File: rtl/sp_ram_banked_pm.sv
// Banked single-port RAM with req/gnt/rvalid handshake, write bypass and per-bank power-down.
module sp_ram_banked_pm
  import sp_ram_pkg::*;
#(
  parameter int unsigned RAM_SIZE    = 32768,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = $clog2(RAM_SIZE),
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    bypass_en_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    sleep_en_i,
  output logic [NUM_BANKS-1:0]    sleep_o
);

  localparam int unsigned BE_W       = DATA_WIDTH / 8;
  localparam int unsigned BYTE_BITS  = $clog2(BE_W);
  localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W     = (BANK_BITS == 0) ? 1 : BANK_BITS;
  localparam int unsigned ROW_W      = ADDR_WIDTH - BYTE_BITS - BANK_BITS;
  localparam int unsigned BANK_WORDS = RAM_SIZE / NUM_BANKS / BE_W;

  logic [BANK_W-1:0]     bank_c;
  logic [ROW_W-1:0]      row_c;
  logic                  gnt_c;
  logic                  bypass_c;
  logic [NUM_BANKS-1:0]  bank_req_c, bank_gnt_c, bank_en_c;
  logic [NUM_BANKS-1:0]  bank_active, bank_sleep, bank_en_allow;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] resp_data_c;

  logic                  rvalid1_q, rvalid1_d;
  logic [BANK_W-1:0]     rbank_q, rbank_d;
  logic                  rbyp_q, rbyp_d;
  logic [DATA_WIDTH-1:0] rbyp_data_q, rbyp_data_d;

  // Decode, grant and per-bank enables; a bypassed write never touches the macro.
  always_comb begin
    bank_c   = BANK_W'(bank_of(32'(addr_i), BYTE_BITS, BANK_BITS));
    row_c    = ROW_W'(row_of(32'(addr_i), BYTE_BITS, BANK_BITS));
    gnt_c    = req_i && bank_active[bank_c];
    bypass_c = we_i && bypass_en_i;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_req_c[b] = req_i && (bank_c == BANK_W'(b));
      bank_gnt_c[b] = gnt_c && bank_req_c[b];
      bank_en_c[b]  = bank_gnt_c[b] && !bypass_c && bank_en_allow[b];
    end
  end

  assign gnt_o = gnt_c;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sp_ram_bank_pm #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_pm (
      .clk            (clk),
      .rst_i          (rst_i),
      .sleep_en_i     (sleep_en_i),
      .req_i          (bank_req_c[g]),
      .gnt_i          (bank_gnt_c[g]),
      .active_o       (bank_active[g]),
      .sleep_o        (bank_sleep[g]),
      .mem_en_allow_o (bank_en_allow[g])
    );

    sp_ram #(
      .ADDR_WIDTH (ROW_W),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (BANK_WORDS)
    ) u_ram (
      .clk     (clk),
      .en_i    (bank_en_c[g]),
      .addr_i  (row_c),
      .we_i    (we_i),
      .be_i    (be_i),
      .wdata_i (wdata_i),
      .rdata_o (bank_rdata[g])
    );
  end

  assign sleep_o = bank_sleep;

  // First response stage: remember which bank answers, or the bypassed write data.
  always_comb begin
    rvalid1_d   = gnt_c;
    rbank_d     = rbank_q;
    rbyp_d      = rbyp_q;
    rbyp_data_d = rbyp_data_q;
    if (gnt_c) begin
      rbank_d = bank_c;
      rbyp_d  = bypass_c;
      if (bypass_c) rbyp_data_d = wdata_i;
    end
    resp_data_c = rbyp_q ? rbyp_data_q : bank_rdata[rbank_q];
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid1_q   <= 1'b0;
      rbank_q     <= '0;
      rbyp_q      <= 1'b0;
      rbyp_data_q <= '0;
    end else begin
      rvalid1_q   <= rvalid1_d;
      rbank_q     <= rbank_d;
      rbyp_q      <= rbyp_d;
      rbyp_data_q <= rbyp_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rvalid2_q, rvalid2_d;
    logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;

    always_comb begin
      rvalid2_d = rvalid1_q;
      rdata2_d  = rvalid1_q ? resp_data_c : rdata2_q;
    end

    always_ff @(posedge clk) begin
      if (rst_i) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid2_d;
        rdata2_q  <= rdata2_d;
      end
    end

    assign rvalid_o = rvalid2_q;
    assign rdata_o  = rdata2_q;
  end else begin : g_no_out_reg
    assign rvalid_o = rvalid1_q;
    assign rdata_o  = resp_data_c;
  end

endmodule

// File: tb/tb_sp_ram_banked_pm.sv
// Scoreboard bench for sp_ram_banked_pm: one DUT without and one with the output register.
module tb_sp_ram_banked_pm;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 15;
  localparam int unsigned NB    = 4;
  localparam int unsigned BEW   = 4;
  localparam int unsigned NWORD = 32;

  logic           clk = 1'b0;
  logic           rst_i, req_i, we_i, bypass_en_i, sleep_en_i;
  logic [AW-1:0]  addr_i;
  logic [BEW-1:0] be_i;
  logic [DW-1:0]  wdata_i;
  logic           gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0]  rdata0, rdata1;
  logic [NB-1:0]  sleep0, sleep1;

  always #5 clk = ~clk;

  sp_ram_banked_pm #(.OUT_REG(0)) u_dut0 (
    .clk(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt0), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .bypass_en_i(bypass_en_i),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .sleep_en_i(sleep_en_i), .sleep_o(sleep0)
  );

  sp_ram_banked_pm #(.OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt1), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .bypass_en_i(bypass_en_i),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .sleep_en_i(sleep_en_i), .sleep_o(sleep1)
  );

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [NWORD];
  int          cyc    = 0;
  int          n_pass = 0;
  int          n_chk  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors: each rvalid pops the oldest expected response; reset drops pending ones.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) fail_now("dut0 unexpected rvalid");
      else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 latency", 32'(cyc), 32'(e.due));
        if (e.chk) check("dut0 rdata", rdata0, e.data);
      end
    end
    if (rst_i) q0.delete();
  end

  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) fail_now("dut1 unexpected rvalid");
      else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 latency", 32'(cyc), 32'(e.due));
        if (e.chk) check("dut1 rdata", rdata1, e.data);
      end
    end
    if (rst_i) q1.delete();
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic access(input int unsigned word, input bit we, input logic [3:0] be,
                        input logic [31:0] wd, input bit byp, output int waited);
    exp_t e;
    bit   granted;
    addr_i      = AW'(word * 4);
    we_i        = we;
    be_i        = be;
    wdata_i     = wd;
    bypass_en_i = byp;
    req_i       = 1'b1;
    granted     = 1'b0;
    waited      = 0;
    while (!granted && waited <= 20) begin
      @(negedge clk);
      if (gnt0 !== gnt1) fail_now("gnt differs between instances");
      if (gnt0 === 1'b1) begin
        granted = 1'b1;
        e.chk   = !we || byp;
        e.data  = we ? wd : model[word];
        if (we && !byp) model[word] = merge(model[word], wd, be);
        e.due = cyc + 1;
        q0.push_back(e);
        e.due = cyc + 2;
        q1.push_back(e);
      end else begin
        waited++;
        @(posedge clk);
        #1;
      end
    end
    if (!granted) fail_now("grant timeout");
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; bypass_en_i = 1'b0; sleep_en_i = 1'b0;
    addr_i = '0; be_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rvalid dut0", 32'(rvalid0), 32'd0);
    check("reset rvalid dut1", 32'(rvalid1), 32'd0);
    check("reset rdata dut1", rdata1, 32'd0);
    check("reset sleep dut0", 32'(sleep0), 32'd0);
    check("reset sleep dut1", 32'(sleep1), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    for (int unsigned i = 0; i < NWORD; i++) begin
      model[i] = 32'hx;
      access(i, 1'b1, 4'hF, $urandom, 1'b0, w);
    end

    // Directed: full write/read, partial byte write, bypass, four-bank streaming.
    access(0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, w);
    access(0, 1'b0, 4'hF, 32'h0, 1'b0, w);
    access(0, 1'b1, 4'b0010, 32'h11223344, 1'b0, w);
    access(0, 1'b0, 4'hF, 32'h0, 1'b0, w);
    check("partial write model", model[0], 32'hDEAD33EF);
    access(4, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1, w);
    access(4, 1'b0, 4'hF, 32'h0, 1'b0, w);
    for (int unsigned i = 0; i < 4; i++) access(i, 1'b0, 4'hF, 32'h0, 1'b0, w);

    // Random traffic with sleep disabled: every request is granted at once.
    for (int k = 0; k < 300; k++) begin
      int unsigned wd_i;
      bit          we_r, byp_r;
      wd_i  = $urandom_range(0, NWORD - 1);
      we_r  = 1'($urandom);
      byp_r = we_r && ($urandom_range(0, 3) == 0);
      access(wd_i, we_r, 4'($urandom), $urandom, byp_r, w);
      if (w != 0) check("active bank grant delay", 32'(w), 32'd0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Sleep: others already idle long enough; bank 1 sleeps 16 idle cycles after its grant.
    idle(20);
    sleep_en_i = 1'b1;
    access(1, 1'b0, 4'hF, 32'h0, 1'b0, w);
    repeat (16) @(negedge clk);
    check("sleep before bank1 expiry", 32'(sleep0), 32'b1101);
    @(negedge clk);
    check("sleep bank1 asleep dut0", 32'(sleep0), 32'b1111);
    check("sleep bank1 asleep dut1", 32'(sleep1), 32'b1111);
    @(posedge clk);
    #1;
    access(1, 1'b0, 4'hF, 32'h0, 1'b0, w);
    check("wake grant delay", 32'(w), 32'd3);
    sleep_en_i = 1'b0;
    @(negedge clk);
    check("bank1 awake", 32'(sleep0), 32'b1101);
    @(posedge clk);
    #1;
    idle(20);
    @(negedge clk);
    check("sleep_en low keeps state", 32'(sleep1), 32'b1101);
    @(posedge clk);
    #1;

    // Reset the cycle after a read grant drops the registered response.
    access(4, 1'b0, 4'hF, 32'h0, 1'b0, w);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset drops dut1 rvalid", 32'(rvalid1), 32'd0);
    check("reset dut0 rvalid", 32'(rvalid0), 32'd0);
    check("reset clears sleep dut0", 32'(sleep0), 32'd0);
    check("reset clears sleep dut1", 32'(sleep1), 32'd0);
    check("reset clears rdata dut1", rdata1, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    access(4, 1'b0, 4'hF, 32'h0, 1'b0, w);
    check("post reset grant delay", 32'(w), 32'd0);
    access(0, 1'b0, 4'hF, 32'h0, 1'b0, w);
    idle(4);
    @(negedge clk);
    check("all responses seen", 32'(q0.size() + q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sp_ram_banked_pm.md
# sp_ram_banked_pm

Parametrised, banked single-port data RAM for the AXI port memory subsystem. It adds a req/gnt/rvalid handshake, an optional output register and per-bank idle power-down with timed wake-up in front of word-interleaved `sp_ram` instances. Write bypass is kept: a bypassed write returns its data without updating memory. It sits behind the AXI-to-mem bridge in place of the single-macro wrapper.

## Interface
- `RAM_SIZE`, 32768: total capacity in bytes.
- `DATA_WIDTH`, 32: word width; multiple of 8.
- `ADDR_WIDTH`, `$clog2(RAM_SIZE)`: byte address width.
- `NUM_BANKS`, 4: power of two, ≥1; banks word-interleaved.
- `OUT_REG`, 0: 0 or 1; adds one output pipeline stage.
- `IDLE_CYCLES`, 16: idle cycles before a bank sleeps; 0 disables sleep.
- `WAKE_CYCLES`, 2: stall cycles for a sleeping bank to wake; ≥1.
- `clk` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: access request.
- `gnt_o` out 1: request accepted this cycle.
- `addr_i` in `ADDR_WIDTH`: byte address; low `$clog2(DATA_WIDTH/8)` bits ignored.
- `we_i` in 1: 1 = write.
- `be_i` in `DATA_WIDTH/8`: byte enables for writes.
- `wdata_i` in `DATA_WIDTH`: write data.
- `bypass_en_i` in 1: on a write, suppress the memory update and return `wdata_i`.
- `rvalid_o` out 1: response valid.
- `rdata_o` out `DATA_WIDTH`: response data.
- `sleep_en_i` in 1: permits banks to enter SLEEP.
- `sleep_o` out `NUM_BANKS`: per-bank sleep indication (bank in SLEEP or WAKE).

## Operation
- Word address: `addr_i[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]`.
  - Bank = low `$clog2(NUM_BANKS)` bits of the word address.
  - Row = the remaining bits.
  - Each bank holds `RAM_SIZE/NUM_BANKS` bytes.
- Handshake (OBI style):
  - `gnt_o = req_i && state[bank]==ACTIVE`, combinational.
  - The master holds `req_i`, `addr_i`, `we_i`, `be_i`, `wdata_i` and `bypass_en_i` stable until granted.
  - The access is issued to the bank in the grant cycle.
  - Exactly one `rvalid_o` follows every grant, including writes.
- Response data:
  - Read: memory word.
  - Bypassed write: `wdata_i` of that write; memory unchanged.
  - Normal write: `rdata_o` undefined; bank written under `be_i`.
- Per-bank power FSM, states ACTIVE, SLEEP, WAKE:
  - ACTIVE: the idle counter increments each cycle without a grant to the bank and clears on a grant. When counter==`IDLE_CYCLES`-1, `sleep_en_i`=1 and `IDLE_CYCLES`≠0, go to SLEEP and clear the counter.
  - SLEEP: the bank macro's enable is held low and contents are retained. `req_i` targeting this bank moves it to WAKE, with counter=0.
  - WAKE: the counter increments; at counter==`WAKE_CYCLES`-1 go to ACTIVE. Requests are not granted in WAKE.
  - `sleep_en_i`=0 only blocks ACTIVE→SLEEP; it does not wake sleeping banks.
- Non-targeted banks are unaffected by a request to another bank.

## Timing
- Reset, applied for one or more cycles:
  - All banks ACTIVE, all counters 0.
  - `rvalid_o`=0, `rdata_o`=0 (OUT_REG=1 register), `sleep_o`=0.
  - In-flight responses are dropped.
  - Memory contents are not cleared.
- Latency from the grant edge:
  - OUT_REG=0: `rvalid_o` one cycle after grant; `rdata_o` driven from the granted bank, selected by the registered bank index.
  - OUT_REG=1: `rvalid_o`/`rdata_o` two cycles after grant, from registers.
- Throughput: one grant per cycle; back-to-back grants to any banks are allowed.
- Sleeping-bank access: `req_i` rises at cycle t and `gnt_o` rises at t+`WAKE_CYCLES`+1.
- `sleep_o[b]` is registered and reflects the state (SLEEP or WAKE) in the same cycle as the FSM.
- A grant in the same cycle the idle counter would expire keeps the bank ACTIVE: the grant wins.
- Read after write to the same address, granted on consecutive cycles: the read returns the new data.

## Structure
- `sp_ram_pkg`: `bank_state_e` (ACTIVE, SLEEP, WAKE) and a bank/row split helper function.
- Sub-module `sp_ram_bank_pm`: one bank's FSM and counter, instantiated `NUM_BANKS` times; outputs `active`, `sleep`, `mem_en_allow`.
- Each bank instantiates the existing generic `sp_ram`, sized `RAM_SIZE/NUM_BANKS`.
- Top level: bank decode, grant, response pipeline and output mux.

## Test plan
- Reset with defaults: write 0xDEADBEEF to 0x0, then read 0x0. Expect `rvalid_o` one cycle after each grant; read data 0xDEADBEEF.
- `be_i`=4'b0010 write of 0x11223344 over 0xDEADBEEF, then read → 0xDEAD33EF.
- Bypass write of 0xCAFEF00D to 0x10 with `bypass_en_i`=1 → `rdata_o`=0xCAFEF00D. A subsequent read of 0x10 returns the prior contents.
- OUT_REG=1, reads to 0x0, 0x4, 0x8, 0xC on four consecutive cycles:
  - Four grants, four `rvalid_o` pulses two cycles after each.
  - Correct data in order across all four banks.
- Sleep/wake:
  - `sleep_en_i`=1, bank 1 idle for 16 cycles → `sleep_o[1]`=1.
  - Read of 0x4 → `gnt_o` 3 cycles after `req_i`; data retained; `sleep_o[1]`=0 after wake.
- Assert `rst_i` the cycle after a read grant → no `rvalid_o`, all `sleep_o`=0, next read returns preserved contents.
